// File: rtl/fixed_point_acc_scheduler_pkg.sv
// Shared types and width helpers for the accumulator scheduler.
// The state encoding and derived widths live here so the top and the arbiter agree.
package acc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Requester ID width; never below one bit.
  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Watchdog counter width; a disabled watchdog still gets a one-bit counter.
  function automatic int wd_w(input int timeout_cycles);
    return (timeout_cycles <= 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/fixed_point_acc_scheduler_arbiter.sv
// Round-robin grant logic with its pointer register.
// The grant is combinational; the pointer only moves when update_en marks a real transfer.
module round_robin_arbiter
  import acc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               update_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_reg;

  // First pass searches from the pointer upward, second pass wraps to the bottom.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && valid[i] && (ID_W'(i) >= ptr_reg)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && valid[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (update_en) begin
      ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_acc_scheduler.sv
// Time-shares one fixed-point accumulator between NUM_REQ requesters.
// Operands are latched on accept and held for the whole run; results come back tagged with the requester ID.
module fixed_point_acc_scheduler
  import acc_sched_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int ID_W          = id_w(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic [NUM_REQ-1:0]              REQ_VALID,
  input  logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0] REQ_VALUES,
  input  logic [NUM_REQ*WIDTH-1:0]        REQ_BIAS,
  output logic [NUM_REQ-1:0]              REQ_READY,
  output logic                            RES_VALID,
  input  logic                            RES_READY,
  output logic [ID_W-1:0]                 RES_ID,
  output logic [WIDTH-1:0]                RES_VALUE,
  output logic                            RES_OVERFLOW,
  output logic                            RES_ERROR,
  output logic                            BUSY,
  output logic [NUM_INPUTS*WIDTH-1:0]     ACC_VALUES_OUT,
  output logic [WIDTH-1:0]                ACC_BIAS_OUT,
  output logic                            ACC_VALID_OUT,
  input  logic [WIDTH-1:0]                ACC_VALUE_IN,
  input  logic                            ACC_VALID_IN,
  input  logic                            ACC_OVERFLOW_IN
);

  localparam int VW   = NUM_INPUTS * WIDTH;
  localparam int WD_W = wd_w(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t            state_reg;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              accept;
  logic [WD_W-1:0]   wd_cnt_reg;

  logic [VW-1:0]     acc_values_reg;
  logic [WIDTH-1:0]  acc_bias_reg;
  logic              acc_valid_reg;
  logic              res_valid_reg;
  logic [ID_W-1:0]   res_id_reg;
  logic [WIDTH-1:0]  res_value_reg;
  logic              res_overflow_reg;
  logic              res_error_reg;
  logic              busy_reg;

  logic [VW-1:0]     val_slice  [NUM_REQ];
  logic [WIDTH-1:0]  bias_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign val_slice[gi]  = REQ_VALUES[gi*VW +: VW];
    assign bias_slice[gi] = REQ_BIAS[gi*WIDTH +: WIDTH];
  end

  round_robin_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (CLK),
    .rst_n     (RSTN),
    .valid     (REQ_VALID),
    .update_en (accept),
    .grant     (grant),
    .grant_id  (grant_id),
    .any       (grant_any)
  );

  // The grant only carries asserted requesters, so any grant in IDLE is a transfer.
  assign REQ_READY = (state_reg == IDLE) ? grant : '0;
  assign accept    = (state_reg == IDLE) && grant_any;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg        <= IDLE;
      wd_cnt_reg       <= '0;
      acc_values_reg   <= '0;
      acc_bias_reg     <= '0;
      acc_valid_reg    <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_id_reg       <= '0;
      res_value_reg    <= '0;
      res_overflow_reg <= 1'b0;
      res_error_reg    <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_values_reg <= val_slice[grant_id];
            acc_bias_reg   <= bias_slice[grant_id];
            res_id_reg     <= grant_id;
            acc_valid_reg  <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= LAUNCH;
          end
        end
        LAUNCH: begin
          acc_valid_reg <= 1'b0;
          wd_cnt_reg    <= '0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (ACC_VALID_IN) begin
            res_value_reg    <= ACC_VALUE_IN;
            res_overflow_reg <= ACC_OVERFLOW_IN;
            res_error_reg    <= 1'b0;
            res_valid_reg    <= 1'b1;
            state_reg        <= RESULT;
          end else if ((TIMEOUT_CYCLES != 0) && (wd_cnt_reg == WD_LAST)) begin
            res_value_reg    <= '0;
            res_overflow_reg <= 1'b0;
            res_error_reg    <= 1'b1;
            res_valid_reg    <= 1'b1;
            state_reg        <= RESULT;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end
        RESULT: begin
          if (RES_READY) begin
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ACC_VALUES_OUT = acc_values_reg;
  assign ACC_BIAS_OUT   = acc_bias_reg;
  assign ACC_VALID_OUT  = acc_valid_reg;
  assign RES_VALID      = res_valid_reg;
  assign RES_ID         = res_id_reg;
  assign RES_VALUE      = res_value_reg;
  assign RES_OVERFLOW   = res_overflow_reg;
  assign RES_ERROR      = res_error_reg;
  assign BUSY           = busy_reg;

endmodule

// File: tb/tb_fixed_point_acc_scheduler.sv
// Bench for fixed_point_acc_scheduler with a behavioural saturating accumulator attached.
// Table rows drive the arbitration/result path; hand sequences cover backpressure, watchdog and reset.
module tb_fixed_point_acc_scheduler;

  localparam int W   = 8;
  localparam int NI  = 4;
  localparam int NR  = 3;
  localparam int TO  = 8;
  localparam int LAT = 4;

  logic            clk;
  logic            rstn;
  logic [NR-1:0]   req_valid;
  logic [NR*NI*W-1:0] req_values;
  logic [NR*W-1:0] req_bias;
  logic [NR-1:0]   req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [1:0]      res_id;
  logic [W-1:0]    res_value;
  logic            res_overflow;
  logic            res_error;
  logic            busy;
  logic [NI*W-1:0] acc_values;
  logic [W-1:0]    acc_bias;
  logic            acc_launch;
  logic [W-1:0]    acc_value_in;
  logic            acc_valid_in;
  logic            acc_ovf_in;

  // accumulator model state
  int              m_cnt;
  logic            m_valid;
  logic [W-1:0]    m_value;
  logic            m_ovf;
  logic            mute;
  logic            late;
  int              pulses;

  int checks;
  int errors;

  fixed_point_acc_scheduler #(
    .WIDTH(W), .NUM_INPUTS(NI), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid), .REQ_VALUES(req_values), .REQ_BIAS(req_bias), .REQ_READY(req_ready),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_ID(res_id), .RES_VALUE(res_value),
    .RES_OVERFLOW(res_overflow), .RES_ERROR(res_error), .BUSY(busy),
    .ACC_VALUES_OUT(acc_values), .ACC_BIAS_OUT(acc_bias), .ACC_VALID_OUT(acc_launch),
    .ACC_VALUE_IN(acc_value_in), .ACC_VALID_IN(acc_valid_in), .ACC_OVERFLOW_IN(acc_ovf_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed sum of bias and operands, saturated to the 8-bit range with an overflow flag.
  function automatic logic [8:0] acc_model(input logic [31:0] v, input logic [7:0] b);
    int s;
    s = int'($signed(b));
    for (int k = 0; k < NI; k++) s += int'($signed(v[k*8 +: 8]));
    if (s > 127)  return {1'b1, 8'h7f};
    if (s < -128) return {1'b1, 8'h80};
    return {1'b0, s[7:0]};
  endfunction

  // Operands are summed at the end of the run, so unstable operands would show up as wrong results.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_value <= '0;
      m_ovf   <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (acc_launch) begin
        m_cnt <= LAT;
        m_ovf <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !mute) begin
          m_valid <= 1'b1;
          {m_ovf, m_value} <= acc_model(acc_values, acc_bias);
        end
      end
    end
  end

  always @(posedge clk) if (acc_launch) pulses <= pulses + 1;

  assign acc_valid_in = m_valid | late;
  assign acc_value_in = late ? 8'h63 : m_value;
  assign acc_ovf_in   = late ? 1'b1 : m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] vals, input logic [7:0] b);
    req_values[i*32 +: 32] = vals;
    req_bias[i*8 +: 8]     = b;
  endtask

  task automatic wait_res();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    chk("res_arrive", {63'd0, got}, 64'd1);
  endtask

  task automatic run_row(input logic [2:0] mask, input logic [1:0] eid,
                         input logic [7:0] eval, input logic eovf);
    int p0;
    logic [2:0] eg;
    eg = 3'b001 << eid;
    @(negedge clk);
    req_valid = mask;
    #1;
    chk("grant", {61'd0, req_ready}, {61'd0, eg});
    p0 = pulses;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("launch", {63'd0, acc_launch}, 64'd1);
    wait_res();
    chk("res_id", {62'd0, res_id}, {62'd0, eid});
    chk("res_value", {56'd0, res_value}, {56'd0, eval});
    chk("res_ovf", {63'd0, res_overflow}, {63'd0, eovf});
    chk("res_err", {63'd0, res_error}, 64'd0);
    chk("one_pulse", 64'(pulses - p0), 64'd1);
    $display("txn mask=%b id=%0d value=%0d ovf=%0d err=%0d", mask, res_id, $signed(res_value),
             res_overflow, res_error);
    @(negedge clk);
    chk("res_consumed", {62'd0, res_valid, busy}, 64'd0);
  endtask

  typedef struct {
    logic [2:0] mask;
    logic [1:0] exp_id;
    logic [7:0] exp_val;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];
  logic [63:0] snap;
  int n;

  initial begin
    checks = 0; errors = 0; pulses = 0;
    rstn = 1'b0; req_valid = '0; req_values = '0; req_bias = '0;
    res_ready = 1'b1; mute = 1'b0; late = 1'b0;

    set_req(0, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd5);           // 15
    set_req(1, {8'hfb, 8'd30, 8'd20, 8'd10}, 8'd1);       // 56
    set_req(2, {8'd127, 8'd127, 8'd127, 8'd127}, 8'd0);   // 508 -> saturate, overflow

    vecs[0] = '{3'b001, 2'd0, 8'd15,  1'b0};
    vecs[1] = '{3'b100, 2'd2, 8'd127, 1'b1};
    vecs[2] = '{3'b111, 2'd0, 8'd15,  1'b0};
    vecs[3] = '{3'b111, 2'd1, 8'd56,  1'b0};
    vecs[4] = '{3'b111, 2'd2, 8'd127, 1'b1};
    vecs[5] = '{3'b111, 2'd0, 8'd15,  1'b0};
    vecs[6] = '{3'b110, 2'd1, 8'd56,  1'b0};
    vecs[7] = '{3'b110, 2'd2, 8'd127, 1'b1};
    vecs[8] = '{3'b110, 2'd1, 8'd56,  1'b0};
    vecs[9] = '{3'b011, 2'd0, 8'd15,  1'b0};

    repeat (2) @(negedge clk);
    chk("rst_res", {res_valid, res_id, res_value, res_overflow, res_error, busy}, 64'd0);
    chk("rst_acc", {acc_launch, acc_bias, acc_values}, 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_row(vecs[i].mask, vecs[i].exp_id, vecs[i].exp_val, vecs[i].exp_ovf);
    end

    // Backpressure: result held for 10 cycles while others wait.
    res_ready = 1'b0;
    @(negedge clk);
    req_valid = 3'b001;
    #1;
    chk("bp_grant", {61'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 3'b110;
    wait_res();
    snap = {52'd0, res_valid, res_id, res_value, res_overflow, res_error};
    chk("bp_result", snap, {52'd0, 1'b1, 2'd0, 8'd15, 1'b0, 1'b0});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {49'd0, req_ready, res_valid, res_id, res_value, res_overflow, res_error},
          {49'd0, 3'b000, snap[12:0]});
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_grant", {61'd0, req_ready}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    wait_res();
    chk("bp_next_res", {62'd0, res_id, res_value}, {54'd0, 2'd1, 8'd56});
    $display("txn backpressure follow-up id=%0d value=%0d", res_id, res_value);
    @(negedge clk);

    // Watchdog: silent accumulator, WAIT spans TIMEOUT_CYCLES cycles after the LAUNCH cycle.
    mute = 1'b1;
    res_ready = 1'b0;
    req_valid = 3'b100;
    #1;
    chk("wd_grant", {61'd0, req_ready}, 64'd4);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    chk("wd_launch", {63'd0, acc_launch}, 64'd1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (res_valid) break;
    end
    chk("wd_latency", 64'(n), 64'(TO + 1));
    chk("wd_result", {53'd0, res_valid, res_id, res_value, res_overflow, res_error},
        {53'd0, 1'b1, 2'd2, 8'd0, 1'b0, 1'b1});
    $display("txn watchdog id=%0d err=%0d value=%0d", res_id, res_error, res_value);
    late = 1'b1;
    @(negedge clk);
    late = 1'b0;
    chk("wd_late_ignored", {53'd0, res_valid, res_id, res_value, res_overflow, res_error},
        {53'd0, 1'b1, 2'd2, 8'd0, 1'b0, 1'b1});
    res_ready = 1'b1;
    @(negedge clk);
    chk("wd_released", {62'd0, res_valid, busy}, 64'd0);
    late = 1'b1;
    @(negedge clk);
    late = 1'b0;
    @(negedge clk);
    chk("late_in_idle", {62'd0, res_valid, busy}, 64'd0);
    mute = 1'b0;

    // Reset during WAIT, pointer at 2 beforehand.
    req_valid = 3'b010;
    #1;
    chk("rw_grant", {61'd0, req_ready}, 64'd2);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("rw_busy", {63'd0, busy}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("rw_res_zero", {res_valid, res_id, res_value, res_overflow, res_error, busy}, 64'd0);
    chk("rw_acc_zero", {acc_launch, acc_bias, acc_values}, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    set_req(1, {8'd1, 8'd1, 8'd1, 8'd1}, 8'd0);
    run_row(3'b110, 2'd1, 8'd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
